// File: rtl/apb4_reg_bridge_if.sv
// APB4 completer-side bus bundle for apb4_reg_bridge.
// The master modport drives the request signals; the slave modport returns PREADY/PRDATA/PSLVERR.
interface apb4_reg_bridge_if #(
    parameter int ApbAw = 12,
    parameter int DataW = 32
);
    localparam int StrbW = DataW / 8;

    logic [ApbAw-1:0] PADDR;
    logic             PSEL;
    logic             PENABLE;
    logic             PWRITE;
    logic [DataW-1:0] PWDATA;
    logic [StrbW-1:0] PSTRB;
    logic             PREADY;
    logic [DataW-1:0] PRDATA;
    logic             PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb4_reg_bridge.sv
// APB4 completer bridging onto a req/ack register-file port with byte enables and decode errors.
// Define APB4_REG_BRIDGE_TIMEOUT_EN to abort register accesses that exceed TimeoutCycles.
module apb4_reg_bridge #(
    parameter int ApbAw         = 12,
    parameter int RegAw         = 8,
    parameter int DataW         = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    apb4_reg_bridge_if.slave     apb,
    output logic                 req_o,
    output logic                 we_o,
    output logic [RegAw-1:0]     addr_o,
    output logic [DataW-1:0]     wdata_o,
    output logic [DataW/8-1:0]   be_o,
    input  logic                 ack_i,
    input  logic [DataW-1:0]     rdata_i,
    input  logic                 error_i
);
    localparam int StrbW = DataW / 8;
    localparam logic [ApbAw-1:0] AlignMask = ApbAw'(StrbW - 1);

    if (RegAw > ApbAw) begin : g_chk_aw
        $error("apb4_reg_bridge: RegAw must not exceed ApbAw");
    end
    if (DataW != 8 && DataW != 16 && DataW != 32) begin : g_chk_dw
        $error("apb4_reg_bridge: DataW must be 8, 16 or 32");
    end
    if (TimeoutCycles < 2 || TimeoutCycles > 255) begin : g_chk_to
        $error("apb4_reg_bridge: TimeoutCycles must be in 2..255");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [RegAw-1:0]   addr_q, addr_d;
    logic [DataW-1:0]   wdata_q, wdata_d;
    logic [StrbW-1:0]   be_q, be_d;
    logic               pready_q, pready_d;
    logic               pslverr_q, pslverr_d;
    logic [DataW-1:0]   prdata_q, prdata_d;
`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
    logic [7:0]         cnt_q, cnt_d;
`endif

    logic addr_legal;
    assign addr_legal = ((apb.PADDR & AlignMask) == '0) && ((apb.PADDR >> RegAw) == '0);

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        pslverr_d = 1'b0;
        prdata_d  = '0;
`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    if (addr_legal) begin
                        state_d = S_REQ;
                        we_d    = apb.PWRITE;
                        addr_d  = apb.PADDR[RegAw-1:0];
                        wdata_d = apb.PWDATA;
                        be_d    = apb.PWRITE ? apb.PSTRB : '1;
`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
                        cnt_d   = 8'd0;
`endif
                    end else begin
                        // Decode error answers in the first access cycle without touching the register side
                        state_d   = S_DONE;
                        pslverr_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (ack_i) begin
                    state_d   = S_DONE;
                    pslverr_d = error_i;
                    prdata_d  = we_q ? '0 : rdata_i;
                end
`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
                else if (cnt_q == 8'(TimeoutCycles - 1)) begin
                    state_d   = S_DONE;
                    pslverr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Outputs are registered copies of the next state so nothing reaches a port combinationally
        req_d    = (state_d == S_REQ);
        pready_d = (state_d == S_DONE);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
            cnt_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign req_o       = req_q;
    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign be_o        = be_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;
    assign apb.PRDATA  = prdata_q;
endmodule

// File: tb/tb_apb4_reg_bridge.sv
// Scoreboard bench for apb4_reg_bridge: APB driver, register-side responder and response monitor.
// Builds with or without APB4_REG_BRIDGE_TIMEOUT_EN.
module tb_apb4_reg_bridge;
    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        req_o, we_o;
    logic [7:0]  addr_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic        ack_i;
    logic        ack_r = 1'b0;
    logic        late_ack = 1'b0;
    logic [31:0] rdata_i = 32'h1111_1111;
    logic        error_i = 1'b1;

    assign ack_i = ack_r | late_ack;

    apb4_reg_bridge_if #(.ApbAw(12), .DataW(32)) apb ();

    apb4_reg_bridge #(.ApbAw(12), .RegAw(8), .DataW(32), .TimeoutCycles(16)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .apb     (apb),
        .req_o   (req_o),
        .we_o    (we_o),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .be_o    (be_o),
        .ack_i   (ack_i),
        .rdata_i (rdata_i),
        .error_i (error_i)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          delay;
        logic [31:0] rdata;
        logic        err;
        int          len;
    } req_t;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Register-side responder: pops the expected request, checks it every REQ cycle, acks after delay
    req_t cur;
    bit   active = 0;
    int   rcnt = 0;
    always @(negedge PCLK) begin
        if (PRESET) begin
            ack_r   = 1'b0;
            active  = 0;
            rcnt    = 0;
            rdata_i = 32'h1111_1111;
            error_i = 1'b1;
        end else begin
            if (ack_r) begin
                ack_r   = 1'b0;
                rdata_i = 32'h1111_1111;
                error_i = 1'b1;
            end
            if (req_o) begin
                if (!active) begin
                    if (req_q.size() == 0) begin
                        check("unexpected_req", 32'd1, 32'd0);
                        cur = '{we: we_o, addr: addr_o, wdata: wdata_o, be: be_o,
                                delay: 0, rdata: 32'h0, err: 1'b0, len: -1};
                    end else begin
                        cur = req_q.pop_front();
                    end
                    active = 1;
                    rcnt   = 0;
                end
                check("req_we", {31'd0, we_o}, {31'd0, cur.we});
                check("req_addr", {24'd0, addr_o}, {24'd0, cur.addr});
                check("req_be", {28'd0, be_o}, {28'd0, cur.be});
                if (cur.we) check("req_wdata", wdata_o, cur.wdata);
                if (cur.delay >= 0 && rcnt == cur.delay) begin
                    ack_r   = 1'b1;
                    rdata_i = cur.rdata;
                    error_i = cur.err;
                end
                rcnt++;
            end else if (active) begin
                if (cur.len >= 0) check("req_len", rcnt, cur.len);
                active = 0;
            end
        end
    end

    // Response monitor: every PREADY pops one expected response; otherwise outputs must be quiet
    always @(negedge PCLK) begin
        rsp_t r;
        if (apb.PREADY) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_pready", 32'd1, 32'd0);
            end else begin
                r = rsp_q.pop_front();
                check("rsp_cycle", cyc, r.cyc);
                check("rsp_pslverr", {31'd0, apb.PSLVERR}, {31'd0, r.err});
                check("rsp_prdata", apb.PRDATA, r.data);
            end
        end else begin
            check("idle_quiet", {apb.PSLVERR, apb.PRDATA[30:0]} | {31'd0, apb.PRDATA[31]}, 32'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge PCLK);
            apb.PSEL    = 1'b0;
            apb.PENABLE = 1'b0;
        end
    endtask

    task automatic xfer(input logic wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic has_req, input logic [3:0] ebe,
                        input int delay, input logic [31:0] rd, input logic rerr, input int len,
                        input int lat, input logic eerr, input logic [31:0] edata);
        int n;
        @(negedge PCLK);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = wr;
        apb.PADDR   = a;
        apb.PWDATA  = d;
        apb.PSTRB   = s;
        if (has_req)
            req_q.push_back('{we: wr, addr: a[7:0], wdata: d, be: ebe,
                              delay: delay, rdata: rd, err: rerr, len: len});
        rsp_q.push_back('{cyc: cyc + lat, err: eerr, data: edata});
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        n = 0;
        while (!apb.PREADY && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        if (!apb.PREADY) check("xfer_wait_bound", 32'd0, 32'd1);
    endtask

    initial begin
        int hi;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0; apb.PSTRB = '0;

        repeat (2) @(negedge PCLK);
        check("reset_outputs",
              {apb.PREADY, apb.PSLVERR, req_o, we_o, addr_o, be_o},
              32'd0);
        check("reset_data", apb.PRDATA | wdata_o, 32'd0);
        #2 PRESET = 1'b0;

        //   wr    addr    wdata         strb  req ebe   dly rdata         rerr len lat eerr edata
        xfer(1'b1, 12'h010, 32'hA5A5_1234, 4'hF, 1, 4'hF, 0, 32'h55AA_55AA, 0,   1,  2, 0, 32'h0);
        idle(2);
        xfer(1'b0, 12'h004, 32'h1234_5678, 4'h0, 1, 4'hF, 3, 32'hDEAD_BEEF, 0,   4,  5, 0, 32'hDEAD_BEEF);
        idle(1);
        xfer(1'b1, 12'h100, 32'h0000_0001, 4'hF, 0, 4'h0, 0, 32'h0,         0,   0,  1, 1, 32'h0);
        idle(1);
        xfer(1'b0, 12'h006, 32'h0,         4'h0, 0, 4'h0, 0, 32'h0,         0,   0,  1, 1, 32'h0);
        xfer(1'b0, 12'h800, 32'h0,         4'h0, 0, 4'h0, 0, 32'h0,         0,   0,  1, 1, 32'h0);
        idle(1);
        // Errored read followed by back-to-back writes and a read, each set up right after DONE
        xfer(1'b0, 12'h020, 32'h0,         4'h0, 1, 4'hF, 1, 32'h0BAD_F00D, 1,   2,  3, 1, 32'h0BAD_F00D);
        xfer(1'b1, 12'h0FC, 32'hCAFE_F00D, 4'h3, 1, 4'h3, 0, 32'h7777_7777, 0,   1,  2, 0, 32'h0);
        xfer(1'b1, 12'h008, 32'h8765_4321, 4'h0, 1, 4'h0, 2, 32'h6666_6666, 0,   3,  4, 0, 32'h0);
        xfer(1'b0, 12'h0FC, 32'h0,         4'hF, 1, 4'hF, 0, 32'h1357_9BDF, 0,   1,  2, 0, 32'h1357_9BDF);
        idle(2);

`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
        xfer(1'b0, 12'h014, 32'h0,         4'h0, 1, 4'hF, -1, 32'h0,        0,  16, 17, 1, 32'h0);
        @(negedge PCLK);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        late_ack = 1'b1;
        @(negedge PCLK);
        late_ack = 1'b0;
        check("late_ack_ignored", {30'd0, apb.PREADY, req_o}, 32'd0);
        idle(2);
        check("after_late_ack", {30'd0, apb.PREADY, req_o}, 32'd0);
`endif

        // Reset while the register side never answers
        @(negedge PCLK);
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 12'h00C;
        req_q.push_back('{we: 1'b0, addr: 8'h0C, wdata: 32'h0, be: 4'hF,
                          delay: -1, rdata: 32'h0, err: 1'b0, len: -1});
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        hi = 0;
`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
        repeat (4) begin
            if (req_o) hi++;
            @(negedge PCLK);
        end
        check("req_held_before_reset", hi, 4);
`else
        repeat (100) begin
            if (req_o) hi++;
            @(negedge PCLK);
        end
        check("req_held_100", hi, 100);
        check("req_still_high", {31'd0, req_o}, 32'd1);
`endif
        #2 PRESET = 1'b1;
        #1;
        check("async_reset_outputs",
              {apb.PREADY, apb.PSLVERR, req_o, we_o, addr_o, be_o},
              32'd0);
        check("async_reset_data", apb.PRDATA | wdata_o, 32'd0);
        @(negedge PCLK);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        req_q.delete();
        rsp_q.delete();
        #2 PRESET = 1'b0;

        xfer(1'b0, 12'h00C, 32'h0,         4'h0, 1, 4'hF, 1, 32'h2468_ACE0, 0,   2,  3, 0, 32'h2468_ACE0);
        idle(4);

        check("rsp_queue_drained", rsp_q.size(), 0);
        check("req_queue_drained", req_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "global timeout");
    end
endmodule
